// File: rtl/irq_ctrl_wb.sv
// irq_ctrl_wb: N-channel Wishbone interrupt controller (mask, edge/level, pending, priority vector).
// Define IRQ_CTRL_SYNC_EN to pass irq_i through a 2-flop synchronizer first.
module irq_ctrl_wb #(
    parameter int          NUM_IRQ    = 8,
    parameter logic [31:0] RESET_MASK = 32'h0,
    parameter logic [31:0] RESET_MODE = 32'hFFFF_FFFF
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [1:0]         wb_adr_i,
    input  logic [31:0]        wb_dat_i,
    output logic [31:0]        wb_dat_o,
    input  logic               wb_stb_i,
    input  logic               wb_cyc_i,
    input  logic               wb_we_i,
    output logic               wb_ack_o,
    input  logic [NUM_IRQ-1:0] irq_i,
    output logic               Ireq_o,
    input  logic               Iack_i,
    output logic [4:0]         irq_vec_o
);

    localparam logic [1:0] ADR_PEND = 2'd0;
    localparam logic [1:0] ADR_MASK = 2'd1;
    localparam logic [1:0] ADR_MODE = 2'd2;
    localparam logic [1:0] ADR_VEC  = 2'd3;

    logic [NUM_IRQ-1:0] irq_s;
    logic [NUM_IRQ-1:0] irq_prev_q;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] mode_q, mode_d;
    logic               svc_q, svc_d;
    logic [4:0]         isr_q, isr_d;
    logic               ireq_q, ireq_d;
    logic [4:0]         vec_q, vec_d;
    logic               ack_q, ack_d;
    logic [31:0]        dat_q, dat_d;

    logic               wb_acc;
    logic               wr_en;
    logic               rd_en;
    logic               iack_fire;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] w1c;
    logic [NUM_IRQ-1:0] iack_clr;
    logic [NUM_IRQ-1:0] act;
    logic [4:0]         enc;
    logic [31:0]        rdata;
    logic               unused_dat;

    assign unused_dat = ^wb_dat_i;

`ifdef IRQ_CTRL_SYNC_EN
    logic [NUM_IRQ-1:0] sync1_q;
    logic [NUM_IRQ-1:0] sync2_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_i;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq_i;
`endif

    // One wait state: ack can never be asserted two cycles in a row.
    assign wb_acc    = wb_stb_i & wb_cyc_i & ~ack_q;
    assign wr_en     = wb_acc & wb_we_i;
    assign rd_en     = wb_acc & ~wb_we_i;
    assign iack_fire = Iack_i & ireq_q;

    always_comb begin
        w1c = '0;
        if (wr_en && wb_adr_i == ADR_PEND) begin
            w1c = wb_dat_i[NUM_IRQ-1:0];
        end
        for (int i = 0; i < NUM_IRQ; i++) begin
            iack_clr[i] = iack_fire && (vec_q == 5'(i));
        end
        rise = irq_s & ~irq_prev_q;
        // Edge bits: clears first, then a new rise re-sets. Level bits follow the input.
        pend_d = (mode_q & ((pend_q & ~(w1c | iack_clr)) | rise))
               | (~mode_q & irq_s);
    end

    always_comb begin
        mask_d = mask_q;
        mode_d = mode_q;
        if (wr_en && wb_adr_i == ADR_MASK) begin
            mask_d = wb_dat_i[NUM_IRQ-1:0];
        end
        if (wr_en && wb_adr_i == ADR_MODE) begin
            mode_d = wb_dat_i[NUM_IRQ-1:0];
        end
    end

    always_comb begin
        svc_d = svc_q;
        isr_d = isr_q;
        if (wr_en && wb_adr_i == ADR_VEC) begin
            svc_d = 1'b0;
        end
        if (iack_fire) begin
            svc_d = 1'b1;
            isr_d = vec_q;
        end
    end

    always_comb begin
        act = pend_q & mask_q;
        enc = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (act[i]) begin
                enc = 5'(i);
            end
        end
        ireq_d = !svc_q && !iack_fire && (|act);
        vec_d  = ireq_d ? enc : 5'd0;
    end

    always_comb begin
        rdata = '0;
        unique case (wb_adr_i)
            ADR_PEND: rdata[NUM_IRQ-1:0] = pend_q;
            ADR_MASK: rdata[NUM_IRQ-1:0] = mask_q;
            ADR_MODE: rdata[NUM_IRQ-1:0] = mode_q;
            ADR_VEC:  rdata = {svc_q, 26'b0, isr_q};
        endcase
        ack_d = wb_acc;
        dat_d = rd_en ? rdata : 32'h0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            irq_prev_q <= '1;
            pend_q     <= '0;
            mask_q     <= RESET_MASK[NUM_IRQ-1:0];
            mode_q     <= RESET_MODE[NUM_IRQ-1:0];
            svc_q      <= 1'b0;
            isr_q      <= 5'd0;
            ireq_q     <= 1'b0;
            vec_q      <= 5'd0;
            ack_q      <= 1'b0;
            dat_q      <= 32'h0;
        end else begin
            irq_prev_q <= irq_s;
            pend_q     <= pend_d;
            mask_q     <= mask_d;
            mode_q     <= mode_d;
            svc_q      <= svc_d;
            isr_q      <= isr_d;
            ireq_q     <= ireq_d;
            vec_q      <= vec_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
        end
    end

    assign wb_ack_o  = ack_q;
    assign wb_dat_o  = dat_q;
    assign Ireq_o    = ireq_q;
    assign irq_vec_o = vec_q;

endmodule

// File: tb/tb_irq_ctrl_wb.sv
// tb_irq_ctrl_wb: directed scenario bench for irq_ctrl_wb (NUM_IRQ=8, RESET_MASK=1).
module tb_irq_ctrl_wb;

    localparam int N = 8;
`ifdef IRQ_CTRL_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    adr = '0;
    logic [31:0]   dat_i = '0;
    logic [31:0]   dat_o;
    logic          stb = 1'b0;
    logic          cyc = 1'b0;
    logic          we = 1'b0;
    logic          ack;
    logic [N-1:0]  irq = '0;
    logic          ireq;
    logic          iack = 1'b0;
    logic [4:0]    vec;
    logic [31:0]   rd;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    irq_ctrl_wb #(
        .NUM_IRQ(N),
        .RESET_MASK(32'h0000_0001),
        .RESET_MODE(32'hFFFF_FFFF)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .wb_adr_i(adr),
        .wb_dat_i(dat_i),
        .wb_dat_o(dat_o),
        .wb_stb_i(stb),
        .wb_cyc_i(cyc),
        .wb_we_i(we),
        .wb_ack_o(ack),
        .irq_i(irq),
        .Ireq_o(ireq),
        .Iack_i(iack),
        .irq_vec_o(vec)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
        adr = a; dat_i = d; we = 1'b1; stb = 1'b1; cyc = 1'b1;
        tick();
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        tick();
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
        adr = a; we = 1'b0; stb = 1'b1; cyc = 1'b1;
        tick();
        d = dat_o;
        stb = 1'b0; cyc = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        iack = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        irq = 8'h01;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({ack, dat_o, ireq, vec} !== 39'h0) begin
            errors++;
            $display("FAIL reset_outputs: got ack=%b dat=%h ireq=%b vec=%0d want all 0", ack, dat_o, ireq, vec);
        end
        rst = 1'b0;
        repeat (3) tick();
`ifndef IRQ_CTRL_SYNC_EN
        checks++;
        if (ireq !== 1'b0) begin
            errors++;
            $display("FAIL reset_held_no_edge: got ireq=%b want 0", ireq);
        end
        wb_read(2'd0, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL reset_pending: got %h want 00000000", rd);
        end
`endif
        wb_read(2'd1, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL reset_mask: got %h want 00000001", rd);
        end
        wb_read(2'd2, rd);
        checks++;
        if (rd !== 32'hFF) begin
            errors++;
            $display("FAIL reset_mode: got %h want 000000ff", rd);
        end
        irq = 8'h00;
        wb_write(2'd0, 32'h1);
        iack = 1'b1;
        tick();
        iack = 1'b0;
        wb_read(2'd3, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL iack_ignored: got %h want 00000000", rd);
        end
        irq = 8'h01;
        repeat (LAT - 1) tick();
        checks++;
        if (ireq !== 1'b0) begin
            errors++;
            $display("FAIL edge_latency_early: got ireq=%b want 0", ireq);
        end
        tick();
        checks++;
        if (ireq !== 1'b1 || vec !== 5'd0) begin
            errors++;
            $display("FAIL edge_latency: got ireq=%b vec=%0d want 1/0", ireq, vec);
        end
    endtask

    task automatic test_priority();
        irq = '0;
        do_reset();
        wb_write(2'd1, 32'hFF);
        irq = 8'h24;
        tick();
        irq = 8'h00;
        repeat (LAT - 1) tick();
        checks++;
        if (ireq !== 1'b1 || vec !== 5'd2) begin
            errors++;
            $display("FAIL prio_vec: got ireq=%b vec=%0d want 1/2", ireq, vec);
        end
        iack = 1'b1;
        tick();
        iack = 1'b0;
        checks++;
        if (ireq !== 1'b0) begin
            errors++;
            $display("FAIL iack_drop: got ireq=%b want 0", ireq);
        end
        wb_read(2'd0, rd);
        checks++;
        if (rd !== 32'h20) begin
            errors++;
            $display("FAIL iack_clear: got %h want 00000020", rd);
        end
        wb_read(2'd3, rd);
        checks++;
        if (rd !== 32'h8000_0002) begin
            errors++;
            $display("FAIL isr_read: got %h want 80000002", rd);
        end
        checks++;
        if (ireq !== 1'b0) begin
            errors++;
            $display("FAIL no_nesting: got ireq=%b want 0", ireq);
        end
        wb_write(2'd3, 32'h0);
        checks++;
        if (ireq !== 1'b1 || vec !== 5'd5) begin
            errors++;
            $display("FAIL eoi_reassert: got ireq=%b vec=%0d want 1/5", ireq, vec);
        end
    endtask

    task automatic test_level();
        irq = '0;
        do_reset();
        wb_write(2'd2, 32'hF7);
        wb_write(2'd1, 32'h08);
        irq = 8'h08;
        repeat (LAT) tick();
        checks++;
        if (ireq !== 1'b1 || vec !== 5'd3) begin
            errors++;
            $display("FAIL level_req: got ireq=%b vec=%0d want 1/3", ireq, vec);
        end
        wb_write(2'd0, 32'h08);
        wb_read(2'd0, rd);
        checks++;
        if (rd !== 32'h08) begin
            errors++;
            $display("FAIL level_w1c: got %h want 00000008", rd);
        end
        irq = 8'h00;
        repeat (LAT) tick();
        checks++;
        if (ireq !== 1'b0) begin
            errors++;
            $display("FAIL level_drop: got ireq=%b want 0", ireq);
        end
    endtask

    task automatic test_mask();
        irq = '0;
        do_reset();
        wb_write(2'd1, 32'h0);
        irq = 8'h02;
        tick();
        irq = 8'h00;
        repeat (LAT) tick();
        checks++;
        if (ireq !== 1'b0) begin
            errors++;
            $display("FAIL masked_req: got ireq=%b want 0", ireq);
        end
        wb_read(2'd0, rd);
        checks++;
        if (rd !== 32'h02) begin
            errors++;
            $display("FAIL masked_pending: got %h want 00000002", rd);
        end
        wb_write(2'd1, 32'h02);
        checks++;
        if (ireq !== 1'b1 || vec !== 5'd1) begin
            errors++;
            $display("FAIL unmask_req: got ireq=%b vec=%0d want 1/1", ireq, vec);
        end
`ifndef IRQ_CTRL_SYNC_EN
        irq = 8'h02;
        wb_write(2'd0, 32'h02);
        wb_read(2'd0, rd);
        checks++;
        if (rd !== 32'h02) begin
            errors++;
            $display("FAIL w1c_vs_set: got %h want 00000002", rd);
        end
`endif
        irq = 8'h00;
        repeat (LAT) tick();
        wb_write(2'd0, 32'h02);
        wb_read(2'd0, rd);
        checks++;
        if (rd !== 32'h0 || ireq !== 1'b0) begin
            errors++;
            $display("FAIL w1c_clear: got pend=%h ireq=%b want 00000000/0", rd, ireq);
        end
    endtask

    task automatic test_preempt_reset();
        irq = '0;
        do_reset();
        wb_write(2'd1, 32'hFF);
        irq = 8'h10;
        repeat (LAT) tick();
        checks++;
        if (ireq !== 1'b1 || vec !== 5'd4) begin
            errors++;
            $display("FAIL preempt_first: got ireq=%b vec=%0d want 1/4", ireq, vec);
        end
        irq = 8'h11;
        repeat (LAT) tick();
        checks++;
        if (ireq !== 1'b1 || vec !== 5'd0) begin
            errors++;
            $display("FAIL preempt_vec: got ireq=%b vec=%0d want 1/0", ireq, vec);
        end
        iack = 1'b1;
        tick();
        iack = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if ({ack, dat_o, ireq, vec} !== 39'h0) begin
            errors++;
            $display("FAIL midservice_reset: got ack=%b dat=%h ireq=%b vec=%0d want all 0", ack, dat_o, ireq, vec);
        end
        rst = 1'b0;
        wb_read(2'd1, rd);
        checks++;
        if (rd !== 32'h1) begin
            errors++;
            $display("FAIL reset_mask_restore: got %h want 00000001", rd);
        end
        wb_read(2'd3, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL reset_service_clear: got %h want 00000000", rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] acks;
        logic [31:0] first;
        irq = '0;
        do_reset();
        adr = 2'd2; we = 1'b0; stb = 1'b1; cyc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            acks[i] = ack;
            if (i == 0) first = dat_o;
        end
        stb = 1'b0; cyc = 1'b0;
        tick();
        checks++;
        if (acks !== 4'b0101 || first !== 32'hFF) begin
            errors++;
            $display("FAIL held_stb_ack: got acks=%b dat=%h want 0101/000000ff", acks, first);
        end
    endtask

    task automatic test_latency();
        int n;
        irq = '0;
        do_reset();
        wb_write(2'd1, 32'h80);
        irq = 8'h80;
        n = 0;
        while (ireq !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (n != LAT || vec !== 5'd7) begin
            errors++;
            $display("FAIL latency: got cycles=%0d vec=%0d want %0d/7", n, vec, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_level();
        test_mask();
        test_preempt_reset();
        test_back_to_back();
        test_latency();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
